// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// It captures the decoded instruction for the EX stage and produces the
// upstream hold request (stall_o) in the same cycle.
//
// Stall semantics: stall_o is combinational and valid throughout the cycle.
// While it is high, the PC and IF/ID must keep their contents so that the ID
// instruction seen now is offered again on the next edge. stall_i is the
// downstream hold request. While it is high this register keeps its contents,
// unless flush_i is also high.
//
// Per-edge priority: flush_i -> bubble, stall_i -> hold, load_use -> bubble,
// otherwise the ID instruction is loaded.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic [DW-1:0] pc4_i,
  input  logic [DW-1:0] rs_data_i,
  input  logic [DW-1:0] rt_data_i,
  input  logic [DW-1:0] imm_ext_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          reg_write_i,
  input  logic          mem_to_reg_i,
  input  logic          mem_read_i,
  input  logic          mem_write_i,
  input  logic          branch_i,
  input  logic          alu_src_i,
  input  logic          reg_dst_i,
  input  logic [2:0]    alu_op_i,
  output logic          valid_o,
  output logic [DW-1:0] pc4_o,
  output logic [DW-1:0] rs_data_o,
  output logic [DW-1:0] rt_data_o,
  output logic [DW-1:0] imm_ext_o,
  output logic [AW-1:0] rs_addr_o,
  output logic [AW-1:0] rt_addr_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          reg_write_o,
  output logic          mem_to_reg_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic          branch_o,
  output logic          alu_src_o,
  output logic          reg_dst_o,
  output logic [2:0]    alu_op_o,
  output logic          stall_o
);

  logic load_use;
  logic bubble;

  // A load in EX whose destination is read by the ID instruction. $zero never counts.
  assign load_use = valid_o & mem_read_o & (rt_addr_o != '0) & valid_i &
                    ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i));

  assign stall_o = stall_i | load_use;

  // flush_i wins over stall_i. A load-use bubble happens only when nothing downstream holds.
  assign bubble = flush_i | (~stall_i & load_use);

  // Pipeline register: reset clears, bubble zeroes, hold keeps, and load captures.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o      <= 1'b0;
      pc4_o        <= '0;
      rs_data_o    <= '0;
      rt_data_o    <= '0;
      imm_ext_o    <= '0;
      rs_addr_o    <= '0;
      rt_addr_o    <= '0;
      rd_addr_o    <= '0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      branch_o     <= 1'b0;
      alu_src_o    <= 1'b0;
      reg_dst_o    <= 1'b0;
      alu_op_o     <= '0;
    end else if (bubble) begin
      valid_o      <= 1'b0;
      pc4_o        <= '0;
      rs_data_o    <= '0;
      rt_data_o    <= '0;
      imm_ext_o    <= '0;
      rs_addr_o    <= '0;
      rt_addr_o    <= '0;
      rd_addr_o    <= '0;
      reg_write_o  <= 1'b0;
      mem_to_reg_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      branch_o     <= 1'b0;
      alu_src_o    <= 1'b0;
      reg_dst_o    <= 1'b0;
      alu_op_o     <= '0;
    end else if (!stall_i) begin
      // An invalid slot still carries its data. Its controls are gated so it has no side effect.
      valid_o      <= valid_i;
      pc4_o        <= pc4_i;
      rs_data_o    <= rs_data_i;
      rt_data_o    <= rt_data_i;
      imm_ext_o    <= imm_ext_i;
      rs_addr_o    <= rs_addr_i;
      rt_addr_o    <= rt_addr_i;
      rd_addr_o    <= rd_addr_i;
      reg_write_o  <= valid_i & reg_write_i;
      mem_to_reg_o <= valid_i & mem_to_reg_i;
      mem_read_o   <= valid_i & mem_read_i;
      mem_write_o  <= valid_i & mem_write_i;
      branch_o     <= valid_i & branch_i;
      alu_src_o    <= valid_i & alu_src_i;
      reg_dst_o    <= valid_i & reg_dst_i;
      alu_op_o     <= valid_i ? alu_op_i : 3'b000;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a directed vector table followed by
// stall, and asynchronous-reset sequences.
module tb_id_ex_reg;

  localparam logic [6:0] RW  = 7'h40;
  localparam logic [6:0] MTR = 7'h20;
  localparam logic [6:0] MR  = 7'h10;
  localparam logic [6:0] MW  = 7'h08;
  localparam logic [6:0] RD  = 7'h01;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [6:0]  ctrl;    // reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst
    logic [2:0]  alu_op;
  } stage_t;

  typedef struct {
    logic   flush;
    logic   stall;
    stage_t in;
    logic   exp_stall;
    stage_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [31:0] pc4_i = '0, rs_data_i = '0, rt_data_i = '0, imm_ext_i = '0;
  logic [4:0]  rs_addr_i = '0, rt_addr_i = '0, rd_addr_i = '0;
  logic        reg_write_i = 0, mem_to_reg_i = 0, mem_read_i = 0, mem_write_i = 0;
  logic        branch_i = 0, alu_src_i = 0, reg_dst_i = 0;
  logic [2:0]  alu_op_i = '0;

  logic        valid_o, stall_o;
  logic [31:0] pc4_o, rs_data_o, rt_data_o, imm_ext_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o;
  logic        branch_o, alu_src_o, reg_dst_o;
  logic [2:0]  alu_op_o;

  stage_t out_s;
  assign out_s = {valid_o, pc4_o, rs_data_o, rt_data_o, imm_ext_o, rs_addr_o, rt_addr_o,
                  rd_addr_o, reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, branch_o,
                  alu_src_o, reg_dst_o, alu_op_o};

  int checks = 0;
  int failures = 0;

  id_ex_reg #(.DW(32), .AW(5)) dut (
    .clk_i(clk), .rst_i(rst_n), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc4_i(pc4_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_ext_i(imm_ext_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .reg_write_i(reg_write_i), .mem_to_reg_i(mem_to_reg_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .branch_i(branch_i), .alu_src_i(alu_src_i),
    .reg_dst_i(reg_dst_i), .alu_op_i(alu_op_i),
    .valid_o(valid_o), .pc4_o(pc4_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
    .imm_ext_o(imm_ext_o), .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .branch_o(branch_o),
    .alu_src_o(alu_src_o), .reg_dst_o(reg_dst_o), .alu_op_o(alu_op_o), .stall_o(stall_o)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic stage_t st(input logic v, input logic [31:0] pc4, input logic [31:0] rsd,
                                input logic [31:0] rtd, input logic [31:0] imm,
                                input logic [4:0] rsa, input logic [4:0] rta,
                                input logic [4:0] rda, input logic [6:0] ctrl,
                                input logic [2:0] aop);
    stage_t s;
    s.valid = v; s.pc4 = pc4; s.rs_data = rsd; s.rt_data = rtd; s.imm = imm;
    s.rs_addr = rsa; s.rt_addr = rta; s.rd_addr = rda; s.ctrl = ctrl; s.alu_op = aop;
    return s;
  endfunction

  // Expected capture of an invalid ID slot: data kept, valid and controls zero.
  function automatic stage_t killed(input stage_t s);
    stage_t k = s;
    k.valid = 1'b0; k.ctrl = '0; k.alu_op = '0;
    return k;
  endfunction

  function automatic vec_t mkv(input logic fl, input logic sl, input stage_t in,
                               input logic es, input stage_t ex);
    vec_t v;
    v.flush = fl; v.stall = sl; v.in = in; v.exp_stall = es; v.exp = ex;
    return v;
  endfunction

  // Driver
  task automatic drive(input logic fl, input logic sl, input stage_t s);
    flush_i = fl; stall_i = sl; valid_i = s.valid;
    pc4_i = s.pc4; rs_data_i = s.rs_data; rt_data_i = s.rt_data; imm_ext_i = s.imm;
    rs_addr_i = s.rs_addr; rt_addr_i = s.rt_addr; rd_addr_i = s.rd_addr;
    {reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i} = s.ctrl;
    alu_op_i = s.alu_op;
  endtask

  // Scoreboard checks
  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_stage(input string name, input stage_t exp);
    checks++;
    if (out_s !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, out_s, exp);
    end
  endtask

  // One cycle: stall_o is checked mid-cycle and the registers are checked just after the edge.
  task automatic cycle(input string name, input logic exp_stall, input stage_t exp);
    @(negedge clk);
    chk_bit({name, ".stall_o"}, stall_o, exp_stall);
    @(posedge clk);
    #1;
    chk_stage({name, ".regs"}, exp);
  endtask

  vec_t vecs[13];
  stage_t s0, s1, s2, s3, s5, s6, s7, s8, s10, x, y, r;

  initial begin
    s0  = st(1, 32'h104, 32'h11, 32'h22, 32'hFFFF_FF80, 5'd1, 5'd2, 5'd7, RW, 3'b010);
    s1  = st(0, 32'h108, 32'hAAAA_5555, 32'h1234_5678, 32'h0000_7FFF, 5'd3, 5'd4, 5'd5, 7'h7F, 3'b101);
    s2  = st(1, 32'h10C, 32'h1000, 32'h0, 32'h4, 5'd3, 5'd5, 5'd0, RW | MTR | MR | 7'h02, 3'b000);
    s3  = st(1, 32'h110, 32'h33, 32'h44, 32'h8, 5'd5, 5'd6, 5'd9, RW | RD, 3'b001);
    s5  = st(1, 32'h118, 32'h2000, 32'h0, 32'h10, 5'd2, 5'd0, 5'd0, RW | MTR | MR | 7'h02, 3'b000);
    s6  = st(1, 32'h11C, 32'h55, 32'h66, 32'hFFFF_FFFC, 5'd0, 5'd0, 5'd3, RW | RD, 3'b011);
    s7  = st(1, 32'h120, 32'h3000, 32'h0, 32'h20, 5'd4, 5'd9, 5'd0, RW | MTR | MR | 7'h02, 3'b000);
    s8  = st(0, 32'h124, 32'h77, 32'h88, 32'h1, 5'd9, 5'd9, 5'd9, RW | MW, 3'b110);
    s10 = st(1, 32'h128, 32'h99, 32'hAA, 32'h2, 5'd1, 5'd9, 5'd10, RW | RD, 3'b100);

    vecs[0]  = mkv(0, 0, s0,  0, s0);          // plain load, negative immediate kept bit-exact
    vecs[1]  = mkv(0, 0, s1,  0, killed(s1));  // invalid slot: controls forced low
    vecs[2]  = mkv(0, 0, s2,  0, s2);          // lw rt=5 enters EX
    vecs[3]  = mkv(0, 0, s3,  1, '0);          // rs=5 uses it: load-use bubble
    vecs[4]  = mkv(0, 0, s3,  0, s3);          // held instruction loads next edge
    vecs[5]  = mkv(0, 0, s5,  0, s5);          // lw rt=0
    vecs[6]  = mkv(0, 0, s6,  0, s6);          // rs=rt=0: no hazard on $zero
    vecs[7]  = mkv(0, 0, s7,  0, s7);          // lw rt=9
    vecs[8]  = mkv(0, 0, s8,  0, killed(s8));  // invalid ID slot never hazards
    vecs[9]  = mkv(0, 0, s7,  0, s7);          // lw rt=9 again
    vecs[10] = mkv(0, 0, s10, 1, '0);          // rt-field match: load-use bubble
    vecs[11] = mkv(1, 0, s10, 0, '0);          // flush alone
    vecs[12] = mkv(1, 1, s0,  1, '0);          // flush beats stall

    // Reset block: outputs clear asynchronously, before any clock edge.
    #3;
    chk_stage("reset_state", '0);
    chk_bit("reset_stall_o", stall_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].flush, vecs[i].stall, vecs[i].in);
      cycle($sformatf("vec%0d", i), vecs[i].exp_stall, vecs[i].exp);
    end

    // A downstream stall holds everything for 3 cycles while the ID inputs keep changing.
    x = st(1, 32'h200, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8000_0000, 5'd11, 5'd12, 5'd13,
           RW | MW | RD, 3'b111);
    drive(0, 0, x);
    cycle("stall_load", 1'b0, x);
    for (int i = 0; i < 3; i++) begin
      r = st($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)));
      drive(0, 1, r);
      cycle($sformatf("stall_hold%0d", i), 1'b1, x);
    end
    y = st(1, 32'h204, 32'h1, 32'h2, 32'h3, 5'd14, 5'd15, 5'd16, RW | 7'h02, 3'b011);
    drive(0, 0, y);
    cycle("stall_release", 1'b0, y);

    // Reset between edges while a valid store sits in EX.
    x = st(1, 32'h300, 32'h5, 32'h6, 32'h7, 5'd17, 5'd18, 5'd0, MW | 7'h02, 3'b000);
    drive(0, 0, x);
    cycle("pre_reset", 1'b0, x);
    chk_bit("pre_reset_mem_write", mem_write_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_stage("async_reset", '0);
    stall_i = 1'b1;
    #0.5;
    chk_bit("reset_stall_follow", stall_o, 1'b1);
    #0.5;
    rst_n = 1'b1;
    drive(0, 0, y);
    @(posedge clk);
    #1;
    chk_stage("after_reset_load", y);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: DW, 32, datapath width of PC, register operands and extended immediate.
REQ-002 Parameter: AW, 5, register-file address width.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 stall_i  in  1  downstream (EX/MEM) hold request.
REQ-006 flush_i  in  1  branch-taken kill of the instruction entering EX.
REQ-007 valid_i  in  1  ID stage holds a real instruction.
REQ-008 pc4_i, rs_data_i, rt_data_i, imm_ext_i  in  DW each  PC+4, read operands, sign-extended immediate from ID.
REQ-009 rs_addr_i, rt_addr_i, rd_addr_i  in  AW each  register specifiers.
REQ-010 reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, branch_i, alu_src_i, reg_dst_i  in  1 each  ID control.
REQ-011 alu_op_i  in  3  ALU operation class.
REQ-012 valid_o, pc4_o, rs_data_o, rt_data_o, imm_ext_o, rs_addr_o, rt_addr_o, rd_addr_o, all control _o, alu_op_o  out  widths as inputs  registered EX-stage copies.
REQ-013 stall_o  out  1  upstream hold (PC and IF/ID must not advance).

Function
REQ-014 One update per rising edge; latency ID->EX exactly 1 cycle; no combinational path from any _i data/control to its _o.
REQ-015 load_use = valid_o & mem_read_o & (rt_addr_o != 0) & valid_i & (rt_addr_o == rs_addr_i | rt_addr_o == rt_addr_i); combinational from registered state and ID inputs.
REQ-016 stall_o = stall_i | load_use.
REQ-017 Per-edge action, highest priority first: flush_i -> bubble; stall_i -> hold; load_use -> bubble; else load.
REQ-018 Load: every _o takes its _i value; valid_o = valid_i.
REQ-019 Hold: every output register keeps its value.
REQ-020 Bubble: valid_o=0, all control outputs and alu_op_o =0, all data/address outputs =0.
REQ-021 valid_i=0 on a load edge: captured with control outputs forced to 0 (no architectural side effect).
REQ-022 flush_i with stall_i both high: flush wins, bubble inserted.
REQ-023 Load-use bubble lasts exactly one cycle: after bubble, valid_o=0, so load_use deasserts and the held ID instruction loads on the next edge.
REQ-024 rt_addr_o==0 never triggers load_use ($zero).
REQ-025 imm_ext_i passed bit-exact; no re-extension or truncation.

Reset
REQ-026 rst_i low: immediately, independent of clk_i, all outputs registers =0 (valid_o=0, all control=0, data=0); stall_o then follows REQ-016 from inputs.
REQ-027 Reset asserted mid-stall or mid-bubble: state cleared; first edge after rst_i rises performs normal priority evaluation.

Verification
REQ-028 Load: valid_i=1, imm_ext_i=32'hFFFF_FF80, rd_addr_i=7, reg_write_i=1 -> next edge imm_ext_o=32'hFFFF_FF80, rd_addr_o=7, reg_write_o=1, valid_o=1.
REQ-029 Load-use: EX holds lw rt=5 (mem_read_o=1); ID rs_addr_i=5 -> stall_o=1 same cycle, next edge valid_o=0 all control 0, following edge ID instruction loaded, stall_o=0.
REQ-030 Zero reg: EX lw rt=0, ID rs_addr_i=0 -> stall_o=0, normal load.
REQ-031 Stall_i=1 for 3 cycles with changing inputs -> outputs constant 3 cycles, stall_o=1; release -> current inputs loaded.
REQ-032 flush_i=1 and stall_i=1 same edge with reg_write_i=1 -> valid_o=0, reg_write_o=0.
REQ-033 rst_i pulsed low between edges while valid_o=1, mem_write_o=1 -> outputs 0 immediately, before next clk_i edge.
